// File: rtl/pipe_ctrl.sv
// Central pipeline controller: merges stage stall requests, issues exception flushes
// (deferred behind an in-flight memory access), and keeps stall counters and a hang watchdog.
module pipe_ctrl #(
  parameter logic [31:0] INT_VECTOR    = 32'h0000_0020,
  parameter logic [31:0] EXC_VECTOR    = 32'h0000_0040,
  parameter int          STALL_TIMEOUT = 1024,
  parameter int          CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_id,
  input  logic             stallreq_ex,
  input  logic             stallreq_mem,
  input  logic [31:0]      excepttype_i,
  input  logic [31:0]      cp0_epc_i,
  input  logic             clr_cnt,
  output logic [5:0]       stall,
  output logic             flush,
  output logic [31:0]      new_pc,
  output logic [CNT_W-1:0] cnt_id,
  output logic [CNT_W-1:0] cnt_ex,
  output logic [CNT_W-1:0] cnt_mem,
  output logic [CNT_W-1:0] cnt_flush,
  output logic             hang_o
);

  // state      | meaning
  // IDLE       | normal operation, exceptions without a mem stall flush immediately
  // FLUSH_WAIT | exception latched, waiting for the memory access to finish

  typedef enum logic {
    IDLE,
    FLUSH_WAIT
  } state_t;

  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;

  localparam int WD_W = $clog2(STALL_TIMEOUT + 1);
  localparam logic [WD_W-1:0]  WD_LIM  = WD_W'(STALL_TIMEOUT);
  localparam logic [WD_W-1:0]  WD_ONE  = WD_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t state, next_state;

  logic [31:0]     exc_q;
  logic [31:0]     epc_q;
  logic            latch_exc;
  logic [5:0]      req_stall;
  logic [WD_W-1:0] wd_cnt;
  logic [WD_W-1:0] wd_inc;

  function automatic logic [31:0] decode_pc(input logic [31:0] code, input logic [31:0] epc);
    logic [31:0] pc;
    case (code)
      32'h0000_0001: pc = INT_VECTOR;
      32'h0000_000e: pc = epc;
      default:       pc = EXC_VECTOR;
    endcase
    return pc;
  endfunction

  always_comb begin
    req_stall = STALL_NONE;
    if (stallreq_mem)     req_stall = STALL_MEM;
    else if (stallreq_ex) req_stall = STALL_EX;
    else if (stallreq_id) req_stall = STALL_ID;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    stall      = STALL_NONE;
    flush      = 1'b0;
    new_pc     = 32'h0;
    latch_exc  = 1'b0;
    case (state)
      IDLE: begin
        if (excepttype_i != 32'h0) begin
          if (!stallreq_mem) begin
            flush  = 1'b1;
            new_pc = decode_pc(excepttype_i, cp0_epc_i);
          end else begin
            stall      = STALL_MEM;
            latch_exc  = 1'b1;
            next_state = FLUSH_WAIT;
          end
        end else begin
          stall = req_stall;
        end
      end
      FLUSH_WAIT: begin
        // later exceptions are ignored here; the latched one wins
        if (!stallreq_mem) begin
          flush      = 1'b1;
          new_pc     = decode_pc(exc_q, epc_q);
          next_state = IDLE;
        end else begin
          stall = STALL_MEM;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      exc_q <= 32'h0;
      epc_q <= 32'h0;
    end else if (latch_exc) begin
      exc_q <= excepttype_i;
      epc_q <= cp0_epc_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr_cnt) begin
      cnt_id    <= '0;
      cnt_ex    <= '0;
      cnt_mem   <= '0;
      cnt_flush <= '0;
    end else begin
      if (stall == STALL_ID  && cnt_id  != CNT_MAX) cnt_id  <= cnt_id  + CNT_ONE;
      if (stall == STALL_EX  && cnt_ex  != CNT_MAX) cnt_ex  <= cnt_ex  + CNT_ONE;
      if (stall == STALL_MEM && cnt_mem != CNT_MAX) cnt_mem <= cnt_mem + CNT_ONE;
      if (flush && cnt_flush != CNT_MAX) cnt_flush <= cnt_flush + CNT_ONE;
    end
  end

  assign wd_inc = wd_cnt + WD_ONE;

  // the run counter parks at the limit so it cannot wrap while the hang persists
  always_ff @(posedge clk) begin
    if (rst || clr_cnt) begin
      wd_cnt <= '0;
      hang_o <= 1'b0;
    end else if (stall == STALL_NONE) begin
      wd_cnt <= '0;
    end else begin
      if (wd_cnt != WD_LIM) wd_cnt <= wd_inc;
      if (wd_inc == WD_LIM) hang_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with a small counter width and short watchdog timeout.
module tb_pipe_ctrl;

  logic        clk;
  logic        rst;
  logic        stallreq_id;
  logic        stallreq_ex;
  logic        stallreq_mem;
  logic [31:0] excepttype_i;
  logic [31:0] cp0_epc_i;
  logic        clr_cnt;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic [3:0]  cnt_id;
  logic [3:0]  cnt_ex;
  logic [3:0]  cnt_mem;
  logic [3:0]  cnt_flush;
  logic        hang_o;

  int checks = 0;
  int errors = 0;

  pipe_ctrl #(
    .INT_VECTOR   (32'h0000_0020),
    .EXC_VECTOR   (32'h0000_0040),
    .STALL_TIMEOUT(8),
    .CNT_W        (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stallreq_id (stallreq_id),
    .stallreq_ex (stallreq_ex),
    .stallreq_mem(stallreq_mem),
    .excepttype_i(excepttype_i),
    .cp0_epc_i   (cp0_epc_i),
    .clr_cnt     (clr_cnt),
    .stall       (stall),
    .flush       (flush),
    .new_pc      (new_pc),
    .cnt_id      (cnt_id),
    .cnt_ex      (cnt_ex),
    .cnt_mem     (cnt_mem),
    .cnt_flush   (cnt_flush),
    .hang_o      (hang_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance one clock and settle 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    rst = 1'b1; stallreq_id = 1'b0; stallreq_ex = 1'b0; stallreq_mem = 1'b0;
    excepttype_i = 32'h0; cp0_epc_i = 32'h0; clr_cnt = 1'b0;
    tick(); tick();
    rst = 1'b0;
    settle();
    check("reset_stall", {26'h0, stall}, 32'h0);
    check("reset_flush", {31'h0, flush}, 32'h0);
    check("reset_new_pc", new_pc, 32'h0);

    for (int i = 0; i < 10; i++) tick();
    check("idle_cnt_id", {28'h0, cnt_id}, 32'h0);
    check("idle_cnt_ex", {28'h0, cnt_ex}, 32'h0);
    check("idle_cnt_mem", {28'h0, cnt_mem}, 32'h0);
    check("idle_cnt_flush", {28'h0, cnt_flush}, 32'h0);
    check("idle_hang", {31'h0, hang_o}, 32'h0);

    // id + ex together: ex wins
    stallreq_id = 1'b1; stallreq_ex = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("idex_stall", {26'h0, stall}, 32'h0000_000f);
      tick();
    end
    stallreq_id = 1'b0; stallreq_ex = 1'b0;
    settle();
    check("idex_cnt_ex", {28'h0, cnt_ex}, 32'd3);
    check("idex_cnt_id", {28'h0, cnt_id}, 32'd0);
    check("id_only_none", {26'h0, stall}, 32'h0);
    stallreq_id = 1'b1;
    settle();
    check("id_only_stall", {26'h0, stall}, 32'h0000_0007);
    stallreq_id = 1'b0;
    settle();

    // immediate flush, syscall-class code
    excepttype_i = 32'h8;
    settle();
    check("exc8_flush", {31'h0, flush}, 32'h1);
    check("exc8_new_pc", new_pc, 32'h40);
    check("exc8_stall", {26'h0, stall}, 32'h0);
    tick();
    excepttype_i = 32'h0;
    settle();
    check("exc8_cnt_flush", {28'h0, cnt_flush}, 32'd1);

    excepttype_i = 32'h1;
    settle();
    check("int_new_pc", new_pc, 32'h20);
    tick();
    // unknown code with id/ex requests: flush overrides the stall
    excepttype_i = 32'h33; stallreq_id = 1'b1; stallreq_ex = 1'b1;
    settle();
    check("other_new_pc", new_pc, 32'h40);
    check("other_flush", {31'h0, flush}, 32'h1);
    check("other_stall", {26'h0, stall}, 32'h0);
    tick();
    excepttype_i = 32'h0; stallreq_id = 1'b0; stallreq_ex = 1'b0;
    settle();
    check("other_cnt_flush", {28'h0, cnt_flush}, 32'd3);
    check("other_cnt_ex", {28'h0, cnt_ex}, 32'd3);

    // eret deferred behind a memory access; later code must be ignored
    excepttype_i = 32'he; cp0_epc_i = 32'h1234; stallreq_mem = 1'b1;
    settle();
    check("defer_c1_stall", {26'h0, stall}, 32'h0000_001f);
    check("defer_c1_flush", {31'h0, flush}, 32'h0);
    tick();
    excepttype_i = 32'h1; cp0_epc_i = 32'h9999;
    settle();
    check("defer_c2_stall", {26'h0, stall}, 32'h0000_001f);
    check("defer_c2_flush", {31'h0, flush}, 32'h0);
    tick();
    excepttype_i = 32'h0;
    settle();
    check("defer_c3_stall", {26'h0, stall}, 32'h0000_001f);
    tick();
    settle();
    check("defer_c4_stall", {26'h0, stall}, 32'h0000_001f);
    tick();
    stallreq_mem = 1'b0;
    settle();
    check("defer_flush", {31'h0, flush}, 32'h1);
    check("defer_new_pc", new_pc, 32'h1234);
    check("defer_stall", {26'h0, stall}, 32'h0);
    tick();
    settle();
    check("defer_cnt_mem", {28'h0, cnt_mem}, 32'd4);
    check("defer_cnt_flush", {28'h0, cnt_flush}, 32'd4);
    check("defer_back_idle", {31'h0, flush}, 32'h0);

    // watchdog: 8 consecutive stalled cycles
    stallreq_ex = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    check("wd_before", {31'h0, hang_o}, 32'h0);
    tick();
    check("wd_set", {31'h0, hang_o}, 32'h1);
    stallreq_ex = 1'b0;
    tick(); tick(); tick();
    check("wd_sticky", {31'h0, hang_o}, 32'h1);
    check("wd_cnt_ex", {28'h0, cnt_ex}, 32'd11);
    // clear wins over a same-cycle increment
    clr_cnt = 1'b1; stallreq_ex = 1'b1;
    tick();
    clr_cnt = 1'b0; stallreq_ex = 1'b0;
    settle();
    check("clr_hang", {31'h0, hang_o}, 32'h0);
    check("clr_cnt_ex", {28'h0, cnt_ex}, 32'd0);
    check("clr_cnt_mem", {28'h0, cnt_mem}, 32'd0);
    check("clr_cnt_flush", {28'h0, cnt_flush}, 32'd0);

    // saturation of the 4-bit id counter
    stallreq_id = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    check("sat_reach", {28'h0, cnt_id}, 32'd15);
    for (int i = 0; i < 5; i++) tick();
    check("sat_hold", {28'h0, cnt_id}, 32'd15);
    check("sat_cnt_ex", {28'h0, cnt_ex}, 32'd0);
    stallreq_id = 1'b0;
    tick();

    // reset while waiting discards the pending exception
    excepttype_i = 32'h8; stallreq_mem = 1'b1;
    tick();
    excepttype_i = 32'h0;
    settle();
    check("rstfw_stall", {26'h0, stall}, 32'h0000_001f);
    rst = 1'b1;
    tick();
    rst = 1'b0; stallreq_mem = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("rstfw_no_flush", {31'h0, flush}, 32'h0);
      check("rstfw_stall0", {26'h0, stall}, 32'h0);
      tick();
    end
    check("rstfw_cnt_flush", {28'h0, cnt_flush}, 32'd0);
    check("rstfw_cnt_id", {28'h0, cnt_id}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
